rx_msg_queue: RTL and testbench

- Receive-side message queue that sits directly downstream of the SPI receiver front end.
- Captures each conditioned word on the receiver's single-cycle write-enable pulse and buffers it for the node's routing/processing logic.
- Read side is first-word-fall-through (FWFT): the head word is always presented while the queue is non-empty.
- Reports occupancy, full/empty, and sticky overflow/underflow error flags.

---
 rtl/rx_msg_queue_pkg.sv | 23 ++
 rtl/rx_msg_queue_if.sv | 30 +++
 rtl/rx_msg_queue_mem.sv | 23 ++
 rtl/rx_msg_queue.sv | 92 +++++++++
 tb/tb_rx_msg_queue.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rx_msg_queue_pkg.sv
// Shared definitions for the receive-side message queue: default geometry,
// error-flag layout used by the node status register, and a depth check.
package rx_msg_queue_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

  // Bit positions of the sticky error flags inside the node status register.
  localparam int ERR_OVERFLOW_BIT  = 0;
  localparam int ERR_UNDERFLOW_BIT = 1;

  // Packed so that the field positions line up with the bit indices above.
  typedef struct packed {
    logic underflow;
    logic overflow;
  } err_flags_t;

  // True when n is a power of two inside the supported 2..256 range.
  function automatic bit depth_ok(input int n);
    return (n >= 2) && (n <= 256) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/rx_msg_queue_if.sv
// Producer/consumer bundle for the receive message queue. The queue takes
// the slave side; the receiver front end and consumer use the master side.
interface rx_msg_queue_if
  import rx_msg_queue_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH,
  parameter int depth = DEFAULT_DEPTH,
  localparam int addr_w = $clog2(depth)
);
  logic              wr_en;
  logic [width-1:0]  wr_data;
  logic              rd_en;
  logic [width-1:0]  rd_data;
  logic              empty;
  logic              full;
  logic [addr_w:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clear_err;

  modport slave (
    input  wr_en, wr_data, rd_en, clear_err,
    output rd_data, empty, full, count, overflow, underflow
  );

  modport master (
    output wr_en, wr_data, rd_en, clear_err,
    input  rd_data, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/rx_msg_queue_mem.sv
// Register-array storage for the queue: one write port, asynchronous read.
// Contents are deliberately never reset.
module queue_mem #(
  parameter int width  = 32,
  parameter int depth  = 8,
  parameter int addr_w = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [width-1:0]  wdata,
  input  logic [addr_w-1:0] raddr,
  output logic [width-1:0]  rdata
);
  logic [width-1:0] mem_q [depth];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/rx_msg_queue.sv
// First-word-fall-through receive message queue with occupancy count,
// full/empty decode and sticky overflow/underflow flags.
module rx_msg_queue
  import rx_msg_queue_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH,
  parameter int depth = DEFAULT_DEPTH,
  localparam int addr_w = $clog2(depth)
) (
  input  logic         clk,
  input  logic         reset_n,
  rx_msg_queue_if.slave q
);
  localparam logic [addr_w:0] FULL_CNT = (addr_w + 1)'(depth);

  if (!depth_ok(depth)) begin : g_bad_depth
    $error("rx_msg_queue: depth must be a power of 2 between 2 and 256");
  end

  logic [addr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_w:0]   count_q, count_d;
  err_flags_t        err_q, err_d;
  logic              empty_w, full_w, push_w, pop_w;
  logic [width-1:0]  mem_rdata;

  // Status decodes come only from registered count, so no request-to-flag path.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);

  // A push into a full queue still lands when a pop frees the head slot.
  assign push_w = q.wr_en && (!full_w || q.rd_en);
  assign pop_w  = q.rd_en && !empty_w;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (push_w) wr_ptr_d = wr_ptr_q + addr_w'(1);
    if (pop_w)  rd_ptr_d = rd_ptr_q + addr_w'(1);

    case ({push_w, pop_w})
      2'b10:   count_d = count_q + (addr_w + 1)'(1);
      2'b01:   count_d = count_q - (addr_w + 1)'(1);
      default: count_d = count_q;
    endcase

    // A new error event overrides a simultaneous clear.
    if (q.clear_err) err_d = '0;
    if (q.wr_en && full_w && !q.rd_en) err_d.overflow  = 1'b1;
    if (q.rd_en && empty_w)            err_d.underflow = 1'b1;
  end

  // Control state register; reset discards all queued words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  queue_mem #(
    .width (width),
    .depth (depth),
    .addr_w(addr_w)
  ) u_mem (
    .clk  (clk),
    .we   (push_w),
    .waddr(wr_ptr_q),
    .wdata(q.wr_data),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  // Mask the head word while empty so stale or unwritten entries never leak out.
  assign q.rd_data   = empty_w ? '0 : mem_rdata;
  assign q.empty     = empty_w;
  assign q.full      = full_w;
  assign q.count     = count_q;
  assign q.overflow  = err_q.overflow;
  assign q.underflow = err_q.underflow;
endmodule

// File: tb/tb_rx_msg_queue.sv
// Self-checking bench for rx_msg_queue: table-driven vectors with explicit
// expected status, a word scoreboard for FWFT data order, and hand-written
// sequences for reset, pointer wrap and mid-operation reset.
module tb_rx_msg_queue;
  localparam int W = 32;
  localparam int D = 8;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rx_msg_queue_if #(.width(W), .depth(D)) qif ();

  rx_msg_queue #(.width(W), .depth(D)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .q      (qif.slave)
  );

  typedef struct {
    logic          wr;
    logic          rd;
    logic          clr;
    logic [W-1:0]  data;
    int            cnt;
    logic          emp;
    logic          ful;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the scoreboard, sample #1 after the edge.
  task automatic step(input logic wr, input logic rd, input logic clr, input logic [W-1:0] data);
    bit do_pop, do_push;
    qif.wr_en     = wr;
    qif.rd_en     = rd;
    qif.clear_err = clr;
    qif.wr_data   = data;
    do_pop  = rd && (sb.size() > 0);
    do_push = wr && ((sb.size() < D) || rd);
    if (reset_n) begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(data);
    end
    @(posedge clk);
    #1;
    qif.wr_en     = 1'b0;
    qif.rd_en     = 1'b0;
    qif.clear_err = 1'b0;
    qif.wr_data   = '0;
  endtask

  // Head word and occupancy against the scoreboard.
  task automatic chk_head(input string tag);
    if (sb.size() > 0) chk({tag, " rd_data"}, qif.rd_data, sb[0]);
    else               chk({tag, " rd_data"}, qif.rd_data, 32'h0);
    chk({tag, " count"}, 32'(qif.count), 32'(sb.size()));
  endtask

  initial begin
    qif.wr_en     = 1'b0;
    qif.rd_en     = 1'b0;
    qif.clear_err = 1'b0;
    qif.wr_data   = '0;

    // Reset then idle.
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rst empty",     32'(qif.empty),     32'd1);
    chk("rst full",      32'(qif.full),      32'd0);
    chk("rst count",     32'(qif.count),     32'd0);
    chk("rst overflow",  32'(qif.overflow),  32'd0);
    chk("rst underflow", 32'(qif.underflow), 32'd0);
    chk("rst rd_data",   qif.rd_data,        32'h0);

    // Single push/pop.
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b0, 1'b0});
    // Fill, overflow, set-beats-clear, clear.
    for (int i = 1; i <= D; i++)
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'(i), i, 1'b0, (i == D), 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h9, 8, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 32'h9, 8, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h0, 8, 1'b0, 1'b1, 1'b0, 1'b0});
    // Push with pop while full: no overflow, count holds.
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'hA, 8, 1'b0, 1'b1, 1'b0, 1'b0});
    // Drain: expect 0x2..0x8 then 0xA.
    for (int i = 7; i >= 0; i--)
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0, i, (i == 0), 1'b0, 1'b0, 1'b0});
    // Underflow, clear, clear-with-event, push+pop on empty.
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h0,  0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h0,  0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 32'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'h0,  0, 1'b1, 1'b0, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].data);
      chk({tag, " count"},     32'(qif.count),     32'(tbl[i].cnt));
      chk({tag, " empty"},     32'(qif.empty),     32'(tbl[i].emp));
      chk({tag, " full"},      32'(qif.full),      32'(tbl[i].ful));
      chk({tag, " overflow"},  32'(qif.overflow),  32'(tbl[i].ovf));
      chk({tag, " underflow"}, 32'(qif.underflow), 32'(tbl[i].unf));
      chk_head(tag);
    end

    // Pointer wrap: preload 3, then 20 push+pop pairs, then drain.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i));
    chk_head("wrap pre");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(i));
      chk_head($sformatf("wrap%0d", i));
    end
    while (sb.size() > 0) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk_head("wrap drain");
    end
    chk("wrap underflow", 32'(qif.underflow), 32'd0);

    // Mid-operation reset with 5 stored words; reset beats a concurrent push.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h3000 + 32'(i));
    chk("pre-reset count", 32'(qif.count), 32'd5);
    reset_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'hBAD);
    reset_n = 1'b1;
    sb.delete();
    chk("midrst count",   32'(qif.count),   32'd0);
    chk("midrst empty",   32'(qif.empty),   32'd1);
    chk("midrst rd_data", qif.rd_data,      32'h0);
    step(1'b1, 1'b0, 1'b0, 32'hC0FFEE);
    chk_head("post-rst push");
    chk("post-rst word", qif.rd_data, 32'hC0FFEE);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_head("post-rst pop");
    chk("post-rst empty", 32'(qif.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
